// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single RAM. One request per cycle is
// granted; read data returns through a 2-entry response FIFO per port.
module ram_arbiter #(
    parameter int unsigned AddrBusWidth = 32,
    parameter int unsigned DataBusWidth = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      p0_req_valid,
    output logic                      p0_req_ready,
    input  logic                      p0_req_we,
    input  logic [AddrBusWidth-1:0]   p0_req_addr,
    input  logic [DataBusWidth-1:0]   p0_req_wdata,
    input  logic [DataBusWidth/8-1:0] p0_req_wsel,
    output logic                      p0_resp_valid,
    input  logic                      p0_resp_ready,
    output logic [DataBusWidth-1:0]   p0_resp_data,

    input  logic                      p1_req_valid,
    output logic                      p1_req_ready,
    input  logic                      p1_req_we,
    input  logic [AddrBusWidth-1:0]   p1_req_addr,
    input  logic [DataBusWidth-1:0]   p1_req_wdata,
    input  logic [DataBusWidth/8-1:0] p1_req_wsel,
    output logic                      p1_resp_valid,
    input  logic                      p1_resp_ready,
    output logic [DataBusWidth-1:0]   p1_resp_data,

    output logic                      ram_re,
    output logic [AddrBusWidth-1:0]   ram_r_addr,
    output logic                      ram_we,
    output logic [AddrBusWidth-1:0]   ram_w_addr,
    output logic [DataBusWidth-1:0]   ram_w_data,
    output logic [DataBusWidth/8-1:0] ram_w_sel,
    input  logic [DataBusWidth-1:0]   ram_r_data
);

    localparam int unsigned SelWidth = DataBusWidth / 8;

    // Per-port views of the flat port list, indexed by port number.
    logic [1:0]              req_valid;
    logic [1:0]              req_we;
    logic [1:0]              resp_ready;
    logic [AddrBusWidth-1:0] req_addr  [2];
    logic [DataBusWidth-1:0] req_wdata [2];
    logic [SelWidth-1:0]     req_wsel  [2];

    assign req_valid    = {p1_req_valid, p0_req_valid};
    assign req_we       = {p1_req_we, p0_req_we};
    assign resp_ready   = {p1_resp_ready, p0_resp_ready};
    assign req_addr[0]  = p0_req_addr;
    assign req_addr[1]  = p1_req_addr;
    assign req_wdata[0] = p0_req_wdata;
    assign req_wdata[1] = p1_req_wdata;
    assign req_wsel[0]  = p0_req_wsel;
    assign req_wsel[1]  = p1_req_wsel;

    logic                    last_grant_q;
    logic                    rd_pend_v_q;
    logic                    rd_pend_port_q;
    logic [1:0]              cnt_q  [2];
    logic [DataBusWidth-1:0] head_q [2];
    logic [DataBusWidth-1:0] tail_q [2];

    logic [1:0] resp_valid;
    logic [1:0] pop;
    logic [1:0] push;
    logic [1:0] cand;
    logic [1:0] grant;
    logic [1:0] occ [2];
    logic       gsel;
    logic       rd_grant;

    // Eligibility and round-robin grant; the pop term lets a full port accept a read
    // in the same cycle it frees a slot.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            resp_valid[p] = (cnt_q[p] != 2'd0);
            pop[p]        = resp_valid[p] & resp_ready[p];
            push[p]       = rd_pend_v_q & (rd_pend_port_q == 1'(p));
            occ[p]        = cnt_q[p] + {1'b0, push[p]};
            cand[p]       = req_valid[p] & ~rst & (req_we[p] | (occ[p] != 2'd2) | pop[p]);
        end
        if (&cand) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end else begin
            grant = cand;
        end
        gsel     = grant[1];
        rd_grant = (|grant) & ~req_we[gsel];
    end

    assign p0_req_ready  = grant[0];
    assign p1_req_ready  = grant[1];
    assign p0_resp_valid = resp_valid[0];
    assign p1_resp_valid = resp_valid[1];
    assign p0_resp_data  = head_q[0];
    assign p1_resp_data  = head_q[1];

    // RAM port drive: forwards the granted request, zero when idle.
    always_comb begin
        ram_re     = 1'b0;
        ram_r_addr = '0;
        ram_we     = 1'b0;
        ram_w_addr = '0;
        ram_w_data = '0;
        ram_w_sel  = '0;
        if (|grant) begin
            if (req_we[gsel]) begin
                ram_we     = 1'b1;
                ram_w_addr = req_addr[gsel];
                ram_w_data = req_wdata[gsel];
                ram_w_sel  = req_wsel[gsel];
            end else begin
                ram_re     = 1'b1;
                ram_r_addr = req_addr[gsel];
            end
        end
    end

    // Arbitration history and the one-deep record of which port owns the RAM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q   <= 1'b1;
            rd_pend_v_q    <= 1'b0;
            rd_pend_port_q <= 1'b0;
        end else begin
            if (|grant) begin
                last_grant_q <= grant[1];
            end
            rd_pend_v_q    <= rd_grant;
            rd_pend_port_q <= grant[1];
        end
    end

    // Response FIFOs: head_q is the registered output, tail_q the second slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                cnt_q[p]  <= 2'd0;
                head_q[p] <= '0;
                tail_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                case ({push[p], pop[p]})
                    2'b01: begin
                        head_q[p] <= tail_q[p];
                        cnt_q[p]  <= cnt_q[p] - 2'd1;
                    end
                    2'b10: begin
                        if (cnt_q[p] == 2'd0) begin
                            head_q[p] <= ram_r_data;
                        end else begin
                            tail_q[p] <= ram_r_data;
                        end
                        cnt_q[p] <= cnt_q[p] + 2'd1;
                    end
                    2'b11: begin
                        if (cnt_q[p] == 2'd1) begin
                            head_q[p] <= ram_r_data;
                        end else begin
                            head_q[p] <= tail_q[p];
                            tail_q[p] <= ram_r_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, per-cycle reference model
// and directed scenarios with literal expectations.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_wsel   [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_data  [2];

    logic        ram_re, ram_we;
    logic [31:0] ram_r_addr, ram_w_addr, ram_w_data;
    logic [3:0]  ram_w_sel;
    logic [31:0] ram_r_data = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .p0_req_valid  (req_valid[0]),
        .p0_req_ready  (req_ready[0]),
        .p0_req_we     (req_we[0]),
        .p0_req_addr   (req_addr[0]),
        .p0_req_wdata  (req_wdata[0]),
        .p0_req_wsel   (req_wsel[0]),
        .p0_resp_valid (resp_valid[0]),
        .p0_resp_ready (resp_ready[0]),
        .p0_resp_data  (resp_data[0]),
        .p1_req_valid  (req_valid[1]),
        .p1_req_ready  (req_ready[1]),
        .p1_req_we     (req_we[1]),
        .p1_req_addr   (req_addr[1]),
        .p1_req_wdata  (req_wdata[1]),
        .p1_req_wsel   (req_wsel[1]),
        .p1_resp_valid (resp_valid[1]),
        .p1_resp_ready (resp_ready[1]),
        .p1_resp_data  (resp_data[1]),
        .ram_re        (ram_re),
        .ram_r_addr    (ram_r_addr),
        .ram_we        (ram_we),
        .ram_w_addr    (ram_w_addr),
        .ram_w_data    (ram_w_data),
        .ram_w_sel     (ram_w_sel),
        .ram_r_data    (ram_r_data)
    );

    // ---------------- memories ----------------
    logic [31:0] rmem [logic [31:0]];  // behind the DUT
    logic [31:0] mmem [logic [31:0]];  // reference model view

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_r(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] rd_m(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : init_val(a);
    endfunction

    // Registered-read RAM; controls sampled at negedge to avoid edge races.
    initial begin : ram_model
        logic        re_s, we_s;
        logic [31:0] ra_s, wa_s, wd_s;
        logic [3:0]  ws_s;
        forever begin
            @(negedge clk);
            re_s = ram_re; ra_s = ram_r_addr;
            we_s = ram_we; wa_s = ram_w_addr; wd_s = ram_w_data; ws_s = ram_w_sel;
            @(posedge clk);
            if (re_s) ram_r_data <= rd_r(ra_s);
            if (we_s) rmem[wa_s] = merge(rd_r(wa_s), wd_s, ws_s);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- stimulus queues and drivers ----------------
    logic        s_we   [2][32];
    logic [31:0] s_addr [2][32];
    logic [31:0] s_wd   [2][32];
    logic [3:0]  s_sel  [2][32];
    int          s_head [2] = '{0, 0};
    int          s_tail [2] = '{0, 0};

    task automatic enq(input int p, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] sel);
        s_we[p][s_tail[p]]   = we;
        s_addr[p][s_tail[p]] = a;
        s_wd[p][s_tail[p]]   = wd;
        s_sel[p][s_tail[p]]  = sel;
        s_tail[p]++;
    endtask

    task automatic drv(input int p);
        bit acc;
        forever begin
            @(negedge clk);
            acc = req_valid[p] && req_ready[p] && !rst;
            @(posedge clk);
            #1;
            if (acc) s_head[p]++;
            if (s_head[p] != s_tail[p]) begin
                req_valid[p] = 1'b1;
                req_we[p]    = s_we[p][s_head[p]];
                req_addr[p]  = s_addr[p][s_head[p]];
                req_wdata[p] = s_wd[p][s_head[p]];
                req_wsel[p]  = s_sel[p][s_head[p]];
            end else begin
                req_valid[p] = 1'b0;
                req_we[p]    = 1'b0;
                req_addr[p]  = '0;
                req_wdata[p] = '0;
                req_wsel[p]  = '0;
            end
        end
    endtask

    initial drv(0);
    initial drv(1);

    // ---------------- logs of DUT handshakes ----------------
    int          acc_cyc [2][64];
    int          acc_cnt [2] = '{0, 0};
    int          gl_port [128];
    int          gl_cnt = 0;
    int          rsp_cyc [2][64];
    logic [31:0] rsp_d   [2][64];
    int          rsp_cnt [2] = '{0, 0};

    // ---------------- reference model and per-cycle compare ----------------
    logic [31:0] md   [2][3];
    int          mav  [2][3];
    int          mcnt [2] = '{0, 0};
    int          mlast = 1;

    initial begin : cmp
        int          g;
        bit          ev   [2];
        bit          pop  [2];
        bit          cand [2];
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("rst_req_ready%0d", p), 32'(req_ready[p]), 0);
                    chk($sformatf("rst_resp_valid%0d", p), 32'(resp_valid[p]), 0);
                    chk($sformatf("rst_resp_data%0d", p), resp_data[p], 0);
                    mcnt[p] = 0;
                end
                chk("rst_ram_re", 32'(ram_re), 0);
                chk("rst_ram_we", 32'(ram_we), 0);
                chk("rst_ram_r_addr", ram_r_addr, 0);
                chk("rst_ram_w_addr", ram_w_addr, 0);
                chk("rst_ram_w_data", ram_w_data, 0);
                chk("rst_ram_w_sel", 32'(ram_w_sel), 0);
                mlast = 1;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    ev[p]   = (mcnt[p] > 0) && (mav[p][0] <= cyc);
                    pop[p]  = ev[p] && resp_ready[p];
                    cand[p] = req_valid[p] && (req_we[p] || mcnt[p] < 2 || pop[p]);
                end
                if (cand[0] && cand[1]) g = 1 - mlast;
                else if (cand[0])       g = 0;
                else if (cand[1])       g = 1;
                else                    g = -1;

                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("req_ready%0d", p), 32'(req_ready[p]), 32'(g == p));
                    chk($sformatf("resp_valid%0d", p), 32'(resp_valid[p]), 32'(ev[p]));
                    if (ev[p]) chk($sformatf("resp_data%0d", p), resp_data[p], md[p][0]);
                end
                if (g < 0) begin
                    chk("idle_ram_re", 32'(ram_re), 0);
                    chk("idle_ram_we", 32'(ram_we), 0);
                    chk("idle_ram_r_addr", ram_r_addr, 0);
                    chk("idle_ram_w_addr", ram_w_addr, 0);
                    chk("idle_ram_w_data", ram_w_data, 0);
                    chk("idle_ram_w_sel", 32'(ram_w_sel), 0);
                end else if (req_we[g]) begin
                    chk("wr_ram_we", 32'(ram_we), 1);
                    chk("wr_ram_re", 32'(ram_re), 0);
                    chk("wr_ram_w_addr", ram_w_addr, req_addr[g]);
                    chk("wr_ram_w_data", ram_w_data, req_wdata[g]);
                    chk("wr_ram_w_sel", 32'(ram_w_sel), 32'(req_wsel[g]));
                end else begin
                    chk("rd_ram_re", 32'(ram_re), 1);
                    chk("rd_ram_we", 32'(ram_we), 0);
                    chk("rd_ram_r_addr", ram_r_addr, req_addr[g]);
                end

                for (int p = 0; p < 2; p++) begin
                    if (req_valid[p] && req_ready[p] && acc_cnt[p] < 64 && gl_cnt < 128) begin
                        acc_cyc[p][acc_cnt[p]] = cyc;
                        acc_cnt[p]++;
                        gl_port[gl_cnt] = p;
                        gl_cnt++;
                    end
                    if (resp_valid[p] && resp_ready[p] && rsp_cnt[p] < 64) begin
                        rsp_cyc[p][rsp_cnt[p]] = cyc;
                        rsp_d[p][rsp_cnt[p]]   = resp_data[p];
                        rsp_cnt[p]++;
                    end
                end

                for (int p = 0; p < 2; p++) begin
                    if (pop[p]) begin
                        md[p][0] = md[p][1]; mav[p][0] = mav[p][1];
                        md[p][1] = md[p][2]; mav[p][1] = mav[p][2];
                        mcnt[p]--;
                    end
                end
                if (g >= 0) begin
                    a = req_addr[g];
                    if (req_we[g]) begin
                        mmem[a] = merge(rd_m(a), req_wdata[g], req_wsel[g]);
                    end else if (mcnt[g] < 3) begin
                        md[g][mcnt[g]]  = rd_m(a);
                        mav[g][mcnt[g]] = cyc + 2;
                        mcnt[g]++;
                    end
                    mlast = g;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain(input string nm);
        int b;
        b = 0;
        step(1);
        while (!(s_head[0] == s_tail[0] && s_head[1] == s_tail[1] &&
                 mcnt[0] == 0 && mcnt[1] == 0) && b < 200) begin
            step(1);
            b++;
        end
        if (b >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_%s: actual timeout required idle within 200 cycles", nm);
        end
        step(1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual still running required finished");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : main
        int a0, a1, r0, r1, g0;
        for (int p = 0; p < 2; p++) begin
            req_valid[p] = 0; req_we[p] = 0; req_addr[p] = 0;
            req_wdata[p] = 0; req_wsel[p] = 0; resp_ready[p] = 1;
        end
        rmem[32'h10] = 32'hDEAD_BEEF; mmem[32'h10] = 32'hDEAD_BEEF;
        rmem[32'h20] = 32'hAABB_CCDD; mmem[32'h20] = 32'hAABB_CCDD;
        step(3);
        rst = 1'b0;
        step(1);

        // First read after reset: latency 2, known data.
        a0 = acc_cnt[0]; r0 = rsp_cnt[0];
        enq(0, 0, 32'h10, 0, 0);
        drain("first");
        chk("first_acc_count", 32'(acc_cnt[0] - a0), 1);
        chk("first_rsp_data", rsp_d[0][r0], 32'hDEAD_BEEF);
        chk("first_rsp_latency", 32'(rsp_cyc[0][r0] - acc_cyc[0][a0]), 2);

        // Asynchronous reset mid-cycle with a full port-1 FIFO.
        resp_ready[1] = 0;
        enq(1, 0, 32'h30, 0, 0);
        enq(1, 0, 32'h34, 0, 0);
        step(6);
        chk("prereset_p1_valid", 32'(resp_valid[1]), 1);
        rst = 1'b1;
        #1;
        chk("async_p1_resp_valid", 32'(resp_valid[1]), 0);
        chk("async_p1_resp_data", resp_data[1], 0);
        chk("async_p0_req_ready", 32'(req_ready[0]), 0);
        chk("async_ram_re", 32'(ram_re), 0);
        step(2);
        rst = 1'b0;
        r1 = rsp_cnt[1];
        resp_ready[1] = 1;
        step(5);
        chk("post_reset_no_stale_resp", 32'(rsp_cnt[1] - r1), 0);

        // Round-robin: both ports reading continuously; port 0 wins first after reset.
        g0 = gl_cnt;
        for (int k = 0; k < 4; k++) begin
            enq(0, 0, 32'h400 + 32'(4 * k), 0, 0);
            enq(1, 0, 32'h500 + 32'(4 * k), 0, 0);
        end
        drain("rr");
        chk("rr_grant_count", 32'(gl_cnt - g0), 8);
        for (int k = 0; k < 8; k++) chk($sformatf("rr_grant_port%0d", k), 32'(gl_port[g0 + k]), 32'(k % 2));

        // Backpressure on port 1.
        a0 = acc_cnt[0]; a1 = acc_cnt[1]; r1 = rsp_cnt[1];
        resp_ready[1] = 0;
        for (int k = 0; k < 4; k++) begin
            enq(1, 0, 32'h100 + 32'(4 * k), 0, 0);
            enq(0, 0, 32'h180 + 32'(4 * k), 0, 0);
        end
        step(14);
        chk("bp_p1_accepts", 32'(acc_cnt[1] - a1), 2);
        chk("bp_p0_accepts", 32'(acc_cnt[0] - a0), 4);
        resp_ready[1] = 1;
        drain("bp");
        chk("bp_p1_total", 32'(rsp_cnt[1] - r1), 4);
        chk("bp_first_drain_data", rsp_d[1][r1], init_val(32'h100));
        chk("bp_third_accept_at_pop", 32'(acc_cyc[1][a1 + 2]), 32'(rsp_cyc[1][r1]));

        // Byte-enable write then read.
        a0 = acc_cnt[0]; r0 = rsp_cnt[0];
        enq(0, 1, 32'h20, 32'h1122_3344, 4'b0101);
        enq(0, 0, 32'h20, 0, 0);
        drain("be");
        chk("be_data", rsp_d[0][r0], 32'hAA22_CC44);
        chk("be_latency", 32'(rsp_cyc[0][r0] - acc_cyc[0][a0 + 1]), 2);

        // Write on port 0 then read of the same address on port 1 next cycle.
        a0 = acc_cnt[0]; a1 = acc_cnt[1]; r1 = rsp_cnt[1];
        enq(0, 1, 32'h40, 32'h5, 4'hF);
        step(1);
        enq(1, 0, 32'h40, 0, 0);
        drain("hazard");
        chk("hazard_gap", 32'(acc_cyc[1][a1] - acc_cyc[0][a0]), 1);
        chk("hazard_data", rsp_d[1][r1], 32'h5);

        // Back-to-back reads on port 0.
        a0 = acc_cnt[0]; r0 = rsp_cnt[0];
        for (int k = 0; k < 8; k++) enq(0, 0, 32'h200 + 32'(4 * k), 0, 0);
        drain("b2b");
        chk("b2b_count", 32'(rsp_cnt[0] - r0), 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("b2b_acc%0d", k), 32'(acc_cyc[0][a0 + k] - acc_cyc[0][a0]), 32'(k));
            chk($sformatf("b2b_rsp%0d", k), 32'(rsp_cyc[0][r0 + k] - acc_cyc[0][a0]), 32'(k + 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
